bcd_count_ctrl: RTL and testbench
=================================

Name: bcd_count_ctrl

Overview:
Upstream stage of the 3-digit 7-segment display multiplexer. It turns three raw pushbuttons (run/stop, direction, clear) into a debounced, edge-detected command set. It runs a prescaled up/down BCD counter from 000 to 999 and presents three registered BCD digits, ready for the display scan logic to consume directly. Counting in native BCD removes the divide/modulo logic from the display path.

Parameters:
TICK_DIV, 12_500_000, clk cycles per count tick (4 Hz at 50 MHz); must be >= 2
DEB_CYCLES, 500_000, consecutive stable cycles needed to accept a button level change (10 ms at 50 MHz); must be >= 1

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
ena  in  1  global enable; 0 freezes all state
btn_run  in  1  raw asynchronous button, active-high; each press toggles run/stop
btn_dir  in  1  raw asynchronous button, active-high; each press toggles count direction
btn_clr  in  1  raw asynchronous button, active-high; each press clears the count to 000
bcd_cent  out  4  hundreds digit, 0..9
bcd_dec  out  4  tens digit, 0..9
bcd_uni  out  4  units digit, 0..9
running  out  1  1 = state RUN
dir_down  out  1  1 = counting down
wrap  out  1  one-cycle pulse when the count wraps (999->000 up, 000->999 down)

Behaviour:
- Reset values (asynchronous): all digits 0, running=0, dir_down=0, wrap=0, prescaler 0, synchronizers 0, debounced levels 0, debounce counters 0.
- Per button:
  - 2-FF synchronizer.
  - Debounce counter: it increments while the synced level differs from the debounced level and clears when they match. When it reaches DEB_CYCLES-1, the debounced level flips and the counter clears.
  - Press pulse: one cycle, registered, asserted on the cycle after the debounced level goes 0->1.
  - Release is debounced but produces no pulse.
- FSM with states IDLE and RUN, reset state IDLE.
  - IDLE -> RUN on run press; RUN -> IDLE on run press.
  - running is a registered decode of the state.
- Direction: a dir press toggles dir_down in either state. The change applies from the next tick onward.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN; it holds its value in IDLE.
  - Internal tick pulse is high for one cycle when the prescaler equals TICK_DIV-1, then the prescaler returns to 0.
  - On the RUN->IDLE transition the prescaler clears to 0.
- Counter update: digits update on the tick cycle and are visible the following cycle.
  - Up: units +1. When units=9, units goes to 0 and the carry passes to tens; tens carries to hundreds the same way.
  - Down: borrows symmetrically, with 0 -> 9 at each digit.
  - Digits never leave 0..9.
- wrap: asserted the same cycle the digits show the wrapped value.
- Clear press: digits go to 000 and the prescaler to 0. The FSM state and direction are unchanged.
- Simultaneous events:
  - Clear beats a tick in the same cycle; no wrap pulse is produced.
  - Run and clear pressed together: both take effect.
- ena=0:
  - Prescaler, digits, FSM, direction and debounce counters all hold.
  - Synchronizers keep sampling.
  - Press pulses are suppressed.
  - wrap is forced to 0.
- Reset mid-operation returns immediately to the reset values listed above.

Optional Feature:
SATURATE_AT_LIMIT_EN
- Defined: at 999 counting up, or 000 counting down, a tick leaves the digits unchanged, wrap stays 0, and the FSM goes to IDLE.
- Not defined: wrap-around behaviour as described in Behaviour.

Decomposition:
- Shared package bcd_count_pkg:
  - state typedef (IDLE, RUN)
  - BCD_MAX=4'd9, BCD_MIN=4'd0
  - default constants for TICK_DIV and DEB_CYCLES
- Sub-module button_debounce (synchronizer + debounce counter + press-pulse generator, parameter DEB_CYCLES), instantiated three times.

Test Plan:
1. Bench uses TICK_DIV=4, DEB_CYCLES=3. Release reset, hold btn_run high for 10 cycles -> running=1 at a fixed cycle (2 sync + 3 debounce + 1 pulse + 1 FSM); digits 000 -> 001 -> 002 at 4-cycle intervals.
2. Bounce test: toggle btn_run with a 1-cycle period for 8 cycles, then low -> no press pulse, running unchanged.
3. Run up from 998 -> 999, then 000 with wrap high for exactly 1 cycle; check the 099->100 and 009->010 carries.
4. Dir press at 000 while running -> next tick shows 999 with wrap=1; the following tick shows 998.
5. Clear press asserted on a tick cycle -> digits 000, wrap=0, running remains 1; ena=0 for 20 cycles -> digits frozen and a button press ignored.
6. With SATURATE_AT_LIMIT_EN defined, count up to 999 -> the next tick holds 999, wrap=0, running=0.

Source files
------------

// File: rtl/bcd_count_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_count_pkg
//  Description : Shared types, constants and BCD step helper for the
//                3-digit BCD count controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd_count_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    localparam int TICK_DIV_DFLT   = 12_500_000;
    localparam int DEB_CYCLES_DFLT = 500_000;

    typedef struct packed {
        logic [3:0] cent;
        logic [3:0] dec;
        logic [3:0] uni;
    } bcd3_t;

    // True when this digit rolls over and must pass a carry/borrow on.
    function automatic logic digit_at_lim(input logic [3:0] d, input logic down);
        return down ? (d == BCD_MIN) : (d >= BCD_MAX);
    endfunction

    function automatic logic [3:0] digit_step(input logic [3:0] d, input logic down);
        if (down) begin
            return (d == BCD_MIN) ? BCD_MAX : (d - 4'd1);
        end
        return (d >= BCD_MAX) ? BCD_MIN : (d + 4'd1);
    endfunction

    // One count step in native BCD; carries ripple units -> tens -> hundreds.
    function automatic bcd3_t bcd_step(input bcd3_t v, input logic down);
        bcd3_t r;
        r     = v;
        r.uni = digit_step(v.uni, down);
        if (digit_at_lim(v.uni, down)) begin
            r.dec = digit_step(v.dec, down);
            if (digit_at_lim(v.dec, down)) begin
                r.cent = digit_step(v.cent, down);
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_count_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_count_ctrl_if
//  Description : Button/enable inputs and BCD digit/status outputs of the
//                count controller, grouped for the display pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bcd_count_ctrl_if;
    logic       ena;
    logic       btn_run;
    logic       btn_dir;
    logic       btn_clr;
    logic [3:0] bcd_cent;
    logic [3:0] bcd_dec;
    logic [3:0] bcd_uni;
    logic       running;
    logic       dir_down;
    logic       wrap;

    // Drives buttons/enable, consumes digits and status.
    modport master (
        output ena, btn_run, btn_dir, btn_clr,
        input  bcd_cent, bcd_dec, bcd_uni, running, dir_down, wrap
    );

    // The controller itself.
    modport slave (
        input  ena, btn_run, btn_dir, btn_clr,
        output bcd_cent, bcd_dec, bcd_uni, running, dir_down, wrap
    );
endinterface
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : button_debounce
//  Description : 2-FF synchronizer, stable-level debounce counter and
//                registered one-cycle press pulse for one raw pushbutton.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debounce
    import bcd_count_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DFLT
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_ena,
    input  wire logic i_btn,
    output logic      o_press
);

    localparam int              CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             level_prev_q, level_prev_d;
    logic             press_q, press_d;

    // Next-state: synchronizer always samples; debounce and pulse obey enable.
    always_comb begin
        sync1_d      = i_btn;
        sync2_d      = sync1_q;
        cnt_d        = cnt_q;
        level_d      = level_q;
        level_prev_d = level_q;
        press_d      = 1'b0;
        if (i_ena) begin
            // Rising edge of the debounced level, seen one cycle late.
            press_d = level_q & ~level_prev_q;
            if (sync2_q != level_q) begin
                if (cnt_q == CNT_LAST) begin
                    level_d = ~level_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            press_q      <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_prev_d;
            press_q      <= press_d;
        end
    end

    assign o_press = press_q;

endmodule
`default_nettype wire

// File: rtl/bcd_count_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_count_ctrl
//  Description : Debounced run/dir/clear buttons driving a prescaled up/down
//                BCD counter 000..999 with registered digit outputs.
//  Options     : SATURATE_AT_LIMIT_EN - stop at 999/000 and drop to IDLE
//                instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_count_ctrl
    import bcd_count_pkg::*;
#(
    parameter int TICK_DIV   = TICK_DIV_DFLT,
    parameter int DEB_CYCLES = DEB_CYCLES_DFLT
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    bcd_count_ctrl_if.slave  bus
);

    localparam int              PRE_W    = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic w_run_press;
    logic w_dir_press;
    logic w_clr_press;
    logic w_tick;
    logic w_at_lim;

    state_t           state_q, state_d;
    logic             running_q, running_d;
    logic             dir_q, dir_d;
    logic             wrap_q, wrap_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    bcd3_t            digits_q, digits_d;

    button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
        .clk(clk), .rst_n(rst_n), .i_ena(bus.ena), .i_btn(bus.btn_run), .o_press(w_run_press)
    );
    button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dir (
        .clk(clk), .rst_n(rst_n), .i_ena(bus.ena), .i_btn(bus.btn_dir), .o_press(w_dir_press)
    );
    button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
        .clk(clk), .rst_n(rst_n), .i_ena(bus.ena), .i_btn(bus.btn_clr), .o_press(w_clr_press)
    );

    assign w_tick   = (state_q == ST_RUN) && bus.ena && (presc_q == PRE_LAST);
    assign w_at_lim = dir_q ? (digits_q == {BCD_MIN, BCD_MIN, BCD_MIN})
                            : (digits_q == {BCD_MAX, BCD_MAX, BCD_MAX});

    // Next-state: FSM, prescaler, digits, direction; clear has final say.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q ^ w_dir_press;
        digits_d = digits_q;
        presc_d  = presc_q;
        wrap_d   = 1'b0;

        if (bus.ena && (state_q == ST_RUN)) begin
            presc_d = w_tick ? '0 : (presc_q + PRE_W'(1));
        end

        if (w_tick) begin
`ifdef SATURATE_AT_LIMIT_EN
            if (w_at_lim) begin
                state_d = ST_IDLE;
            end else begin
                digits_d = bcd_step(digits_q, dir_q);
            end
`else
            digits_d = bcd_step(digits_q, dir_q);
            wrap_d   = w_at_lim;
`endif
        end

        if (w_run_press) begin
            state_d = (state_q == ST_RUN) ? ST_IDLE : ST_RUN;
        end

        // Stopping restarts the tick period from zero on the next run.
        if ((state_q == ST_RUN) && (state_d == ST_IDLE)) begin
            presc_d = '0;
        end

        if (w_clr_press) begin
            digits_d = '0;
            presc_d  = '0;
            wrap_d   = 1'b0;
        end

        running_d = (state_d == ST_RUN);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            dir_q     <= 1'b0;
            wrap_q    <= 1'b0;
            presc_q   <= '0;
            digits_q  <= '0;
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
            dir_q     <= dir_d;
            wrap_q    <= wrap_d;
            presc_q   <= presc_d;
            digits_q  <= digits_d;
        end
    end

    assign bus.bcd_cent = digits_q.cent;
    assign bus.bcd_dec  = digits_q.dec;
    assign bus.bcd_uni  = digits_q.uni;
    assign bus.running  = running_q;
    assign bus.dir_down = dir_q;
    assign bus.wrap     = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_count_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_count_ctrl
//  Description : Directed self-checking bench for bcd_count_ctrl with
//                TICK_DIV=4 and DEB_CYCLES=3.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_count_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   chk_cnt = 0;
    int   pass_cnt = 0;

    bcd_count_ctrl_if bus_if ();

    bcd_count_ctrl #(.TICK_DIV(4), .DEB_CYCLES(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] dig();
        return {bus_if.bcd_cent, bus_if.bcd_dec, bus_if.bcd_uni};
    endfunction

    // Waits (bounded) on negedges until the digits show v.
    task automatic wait_digits(input logic [11:0] v, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (dig() == v) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bus_if.ena = 1'b1; bus_if.btn_run = 1'b0; bus_if.btn_dir = 1'b0; bus_if.btn_clr = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_cnt++; if (dig() !== 12'h000) $display("FAIL reset_digits got=%h exp=000", dig()); else pass_cnt++;
        chk_cnt++; if (bus_if.running !== 1'b0) $display("FAIL reset_running got=%b exp=0", bus_if.running); else pass_cnt++;
        chk_cnt++; if (bus_if.dir_down !== 1'b0) $display("FAIL reset_dir got=%b exp=0", bus_if.dir_down); else pass_cnt++;
        chk_cnt++; if (bus_if.wrap !== 1'b0) $display("FAIL reset_wrap got=%b exp=0", bus_if.wrap); else pass_cnt++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Press at T0: 2 sync + 3 debounce + 1 pulse + 1 FSM -> RUN after edge 7.
    task automatic test_run_start();
        bus_if.btn_run = 1'b1;
        repeat (6) @(negedge clk);
        chk_cnt++; if (bus_if.running !== 1'b0) $display("FAIL run_early got=%b exp=0", bus_if.running); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (bus_if.running !== 1'b1) $display("FAIL run_edge7 got=%b exp=1", bus_if.running); else pass_cnt++;
        chk_cnt++; if (dig() !== 12'h000) $display("FAIL run_d0 got=%h exp=000", dig()); else pass_cnt++;
        repeat (3) @(negedge clk);
        chk_cnt++; if (dig() !== 12'h000) $display("FAIL run_d0_hold got=%h exp=000", dig()); else pass_cnt++;
        bus_if.btn_run = 1'b0;
        @(negedge clk);
        chk_cnt++; if (dig() !== 12'h001) $display("FAIL run_d1 got=%h exp=001", dig()); else pass_cnt++;
        repeat (3) @(negedge clk);
        chk_cnt++; if (dig() !== 12'h001) $display("FAIL run_d1_hold got=%h exp=001", dig()); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (dig() !== 12'h002) $display("FAIL run_d2 got=%h exp=002", dig()); else pass_cnt++;
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 8; i++) begin
            bus_if.btn_run = ~bus_if.btn_run;
            @(negedge clk);
        end
        bus_if.btn_run = 1'b0;
        repeat (12) @(negedge clk);
        chk_cnt++; if (bus_if.running !== 1'b1) $display("FAIL bounce_running got=%b exp=1", bus_if.running); else pass_cnt++;
        chk_cnt++; if (bus_if.dir_down !== 1'b0) $display("FAIL bounce_dir got=%b exp=0", bus_if.dir_down); else pass_cnt++;
    endtask

    task automatic test_wrap_up();
        bit ok;
        wait_digits(12'h009, 5000, ok);
        chk_cnt++; if (!ok) $display("FAIL reach_009 got=%h exp=009", dig()); else pass_cnt++;
        repeat (4) @(negedge clk);
        chk_cnt++; if (dig() !== 12'h010) $display("FAIL carry_010 got=%h exp=010", dig()); else pass_cnt++;
        wait_digits(12'h099, 5000, ok);
        chk_cnt++; if (!ok) $display("FAIL reach_099 got=%h exp=099", dig()); else pass_cnt++;
        repeat (4) @(negedge clk);
        chk_cnt++; if (dig() !== 12'h100) $display("FAIL carry_100 got=%h exp=100", dig()); else pass_cnt++;
        wait_digits(12'h998, 5000, ok);
        chk_cnt++; if (!ok) $display("FAIL reach_998 got=%h exp=998", dig()); else pass_cnt++;
        repeat (4) @(negedge clk);
        chk_cnt++; if (dig() !== 12'h999) $display("FAIL up_999 got=%h exp=999", dig()); else pass_cnt++;
        chk_cnt++; if (bus_if.wrap !== 1'b0) $display("FAIL wrap_at_999 got=%b exp=0", bus_if.wrap); else pass_cnt++;
        repeat (4) @(negedge clk);
`ifdef SATURATE_AT_LIMIT_EN
        chk_cnt++; if (dig() !== 12'h999) $display("FAIL sat_hold got=%h exp=999", dig()); else pass_cnt++;
        chk_cnt++; if (bus_if.wrap !== 1'b0) $display("FAIL sat_wrap got=%b exp=0", bus_if.wrap); else pass_cnt++;
        chk_cnt++; if (bus_if.running !== 1'b0) $display("FAIL sat_running got=%b exp=0", bus_if.running); else pass_cnt++;
`else
        chk_cnt++; if (dig() !== 12'h000) $display("FAIL wrap_000 got=%h exp=000", dig()); else pass_cnt++;
        chk_cnt++; if (bus_if.wrap !== 1'b1) $display("FAIL wrap_pulse got=%b exp=1", bus_if.wrap); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (bus_if.wrap !== 1'b0) $display("FAIL wrap_width got=%b exp=0", bus_if.wrap); else pass_cnt++;
`endif
    endtask

    // Clear + dir pressed together at T0: both land at edge 7, prescaler restarts.
    task automatic test_dir_at_zero();
        bus_if.btn_clr = 1'b1; bus_if.btn_dir = 1'b1;
        repeat (7) @(negedge clk);
        chk_cnt++; if (dig() !== 12'h000) $display("FAIL dir_clr_000 got=%h exp=000", dig()); else pass_cnt++;
        chk_cnt++; if (bus_if.dir_down !== 1'b1) $display("FAIL dir_toggle got=%b exp=1", bus_if.dir_down); else pass_cnt++;
        chk_cnt++; if (bus_if.running !== 1'b1) $display("FAIL dir_running got=%b exp=1", bus_if.running); else pass_cnt++;
        repeat (3) @(negedge clk);
        bus_if.btn_clr = 1'b0; bus_if.btn_dir = 1'b0;
        @(negedge clk);
        chk_cnt++; if (dig() !== 12'h999) $display("FAIL down_wrap_999 got=%h exp=999", dig()); else pass_cnt++;
        chk_cnt++; if (bus_if.wrap !== 1'b1) $display("FAIL down_wrap_pulse got=%b exp=1", bus_if.wrap); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (bus_if.wrap !== 1'b0) $display("FAIL down_wrap_width got=%b exp=0", bus_if.wrap); else pass_cnt++;
        repeat (3) @(negedge clk);
        chk_cnt++; if (dig() !== 12'h998) $display("FAIL down_998 got=%h exp=998", dig()); else pass_cnt++;
    endtask

    // Continues from T0+15: clear press at T0+20 lands on the T0+27 tick.
    task automatic test_clear_on_tick();
        repeat (5) @(negedge clk);
        bus_if.btn_clr = 1'b1;
        repeat (7) @(negedge clk);
        chk_cnt++; if (dig() !== 12'h000) $display("FAIL clr_tick_000 got=%h exp=000", dig()); else pass_cnt++;
        chk_cnt++; if (bus_if.wrap !== 1'b0) $display("FAIL clr_tick_wrap got=%b exp=0", bus_if.wrap); else pass_cnt++;
        chk_cnt++; if (bus_if.running !== 1'b1) $display("FAIL clr_running got=%b exp=1", bus_if.running); else pass_cnt++;
        repeat (3) @(negedge clk);
        bus_if.btn_clr = 1'b0;
        @(negedge clk);
        chk_cnt++; if (dig() !== 12'h999) $display("FAIL clr_next_999 got=%h exp=999", dig()); else pass_cnt++;
    endtask

    // Freeze right after a tick: 20 cycles with ena=0 and a run press applied.
    task automatic test_ena_freeze();
        bus_if.ena = 1'b0;
        repeat (2) @(negedge clk);
        bus_if.btn_run = 1'b1;
        repeat (10) @(negedge clk);
        chk_cnt++; if (dig() !== 12'h999) $display("FAIL freeze_mid got=%h exp=999", dig()); else pass_cnt++;
        chk_cnt++; if (bus_if.wrap !== 1'b0) $display("FAIL freeze_wrap got=%b exp=0", bus_if.wrap); else pass_cnt++;
        bus_if.btn_run = 1'b0;
        repeat (8) @(negedge clk);
        chk_cnt++; if (dig() !== 12'h999) $display("FAIL freeze_end got=%h exp=999", dig()); else pass_cnt++;
        chk_cnt++; if (bus_if.running !== 1'b1) $display("FAIL freeze_running got=%b exp=1", bus_if.running); else pass_cnt++;
        bus_if.ena = 1'b1;
        repeat (3) @(negedge clk);
        chk_cnt++; if (dig() !== 12'h999) $display("FAIL resume_hold got=%h exp=999", dig()); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (dig() !== 12'h998) $display("FAIL resume_998 got=%h exp=998", dig()); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        #1;
        chk_cnt++; if (dig() !== 12'h000) $display("FAIL rst_mid_digits got=%h exp=000", dig()); else pass_cnt++;
        chk_cnt++; if (bus_if.running !== 1'b0) $display("FAIL rst_mid_running got=%b exp=0", bus_if.running); else pass_cnt++;
        chk_cnt++; if (bus_if.dir_down !== 1'b0) $display("FAIL rst_mid_dir got=%b exp=0", bus_if.dir_down); else pass_cnt++;
        chk_cnt++; if (bus_if.wrap !== 1'b0) $display("FAIL rst_mid_wrap got=%b exp=0", bus_if.wrap); else pass_cnt++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached, checks=%0d", chk_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_run_start();
        test_bounce();
        test_wrap_up();
`ifndef SATURATE_AT_LIMIT_EN
        test_dir_at_zero();
        test_clear_on_tick();
        test_ena_freeze();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
